// File: rtl/tdm_mux_pkg.sv
// Shared definitions for the four-channel TDM multiplexer:
// the default data width, the channel tag codes and the scheduler state type.
package tdm_mux_pkg;

    localparam int W_DEFAULT = 8;
    localparam int NCH       = 4;

    localparam logic [1:0] CH_A = 2'b00;
    localparam logic [1:0] CH_B = 2'b01;
    localparam logic [1:0] CH_C = 2'b10;
    localparam logic [1:0] CH_D = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_mux_rr_pick.sv
// Round-robin search over four requests. Starting at ptr and wrapping,
// it returns the index of the first asserted request. 'any' flags whether
// any request is asserted at all. The block is purely combinational.
module rr_pick
    import tdm_mux_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  logic [1:0]     ptr,
    output logic [1:0]     grant,
    output logic           any
);

    logic [NCH-1:0] rot;
    logic [1:0]     off;

    // Rotate the requests so that position 0 is the channel ptr points at.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_rot
            logic [1:0] idx;
            assign idx     = ptr + 2'(gi);
            assign rot[gi] = req[idx];
        end
    endgenerate

    // Find the lowest set bit of the rotated vector, which is the nearest request at or after ptr.
    always_comb begin
        off = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (rot[i]) off = 2'(i);
        end
    end

    assign any   = |req;
    assign grant = ptr + off;

endmodule

// File: rtl/tdm_mux.sv
// Four-channel time-division multiplexer. Each channel has a one-entry
// holding register. A scheduler copies the held words into a single output
// register that has valid/ready handshaking.
// Build option TDM_MUX_SKIP_IDLE_EN: when defined, the scheduler skips empty
// channels by using a round-robin search. When undefined, it runs fixed slots
// that visit every channel in turn.
module tdm_mux
    import tdm_mux_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         e,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic         va,
    input  logic         vb,
    input  logic         vc,
    input  logic         vd,
    output logic         ra,
    output logic         rb,
    output logic         rc,
    output logic         rd,
    output logic [W-1:0] y,
    output logic         s1,
    output logic         s2,
    output logic         v,
    input  logic         r
);

    logic [W-1:0]   din  [NCH];
    logic [W-1:0]   hold [NCH];
    logic [NCH-1:0] vld;
    logic [NCH-1:0] full;
    logic [NCH-1:0] rdy;

    state_t       state_reg;
    logic [1:0]   ptr_reg, ptr_next;
    logic [W-1:0] y_reg;
    logic [1:0]   tag_reg;
    logic         v_reg;

    logic       free, slot, load;
    logic [1:0] sel;

    assign din[0] = a;
    assign din[1] = b;
    assign din[2] = c;
    assign din[3] = d;
    assign vld    = {vd, vc, vb, va};

    // Ready is held low throughout reset, so no word can be accepted at the edge where reset is released.
    assign rdy = ~full & {NCH{~rst}};
    assign ra  = rdy[0];
    assign rb  = rdy[1];
    assign rc  = rdy[2];
    assign rd  = rdy[3];

    // Holding registers, one per channel.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic         full_reg;
            logic [W-1:0] hold_reg;

            // Capture only while empty. A drain and a capture never happen on the same edge, because a full register is not ready.
            always_ff @(posedge clk) begin
                if (rst) begin
                    full_reg <= 1'b0;
                end else if (load && (sel == 2'(gi))) begin
                    full_reg <= 1'b0;
                end else if (vld[gi] && !full_reg) begin
                    full_reg <= 1'b1;
                    hold_reg <= din[gi];
                end
            end

            assign full[gi] = full_reg;
            assign hold[gi] = hold_reg;
        end
    endgenerate

    assign free = !v_reg || r;
    assign slot = (state_reg == ST_RUN) && free;

`ifdef TDM_MUX_SKIP_IDLE_EN
    logic [1:0] pick;
    logic       pick_any;

    rr_pick u_pick (
        .req   (full),
        .ptr   (ptr_reg),
        .grant (pick),
        .any   (pick_any)
    );

    // Work-conserving slot: serve the nearest full channel, then resume the search just past it.
    always_comb begin
        sel      = pick;
        load     = slot && pick_any;
        ptr_next = load ? (pick + 2'd1) : ptr_reg;
    end
`else
    // Fixed slot: only the channel under ptr can load, and ptr advances on every consumed slot.
    always_comb begin
        sel      = ptr_reg;
        load     = slot && full[ptr_reg];
        ptr_next = slot ? (ptr_reg + 2'd1) : ptr_reg;
    end
`endif

    // Scheduler FSM and output register. The output holds while it is presented and not yet taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= 2'b00;
            y_reg     <= '0;
            tag_reg   <= CH_A;
            v_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: if (e)  state_reg <= ST_RUN;
                ST_RUN:  if (!e) state_reg <= ST_IDLE;
                default:         state_reg <= ST_IDLE;
            endcase
            ptr_reg <= ptr_next;
            if (free) begin
                if (load) begin
                    y_reg   <= hold[sel];
                    tag_reg <= sel;
                    v_reg   <= 1'b1;
                end else begin
                    v_reg   <= 1'b0;
                end
            end
        end
    end

    assign y  = y_reg;
    assign s1 = tag_reg[1];
    assign s2 = tag_reg[0];
    assign v  = v_reg;

endmodule

// File: tb/tb_tdm_mux.sv
// Self-checking bench for tdm_mux. It applies a table of vectors, then
// directed corner-case sequences, then random traffic. Every cycle is
// compared against a channel/slot reference model.
module tb_tdm_mux;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, e, r;
    logic [W-1:0] din [4];
    logic [3:0]   vin;
    logic [W-1:0] a, b, c, d;
    logic         va, vb, vc, vd;
    logic         ra, rb, rc, rd;
    logic [W-1:0] y;
    logic         s1, s2, v;

    assign a  = din[0];
    assign b  = din[1];
    assign c  = din[2];
    assign d  = din[3];
    assign va = vin[0];
    assign vb = vin[1];
    assign vc = vin[2];
    assign vd = vin[3];

    tdm_mux #(.W(W)) dut (
        .clk(clk), .rst(rst), .e(e),
        .a(a), .b(b), .c(c), .d(d),
        .va(va), .vb(vb), .vc(vc), .vd(vd),
        .ra(ra), .rb(rb), .rc(rc), .rd(rd),
        .y(y), .s1(s1), .s2(s2), .v(v), .r(r)
    );

    int checks   = 0;
    int failures = 0;
    bit verbose  = 1'b1;

    // Reference model state
    bit           m_full [4];
    logic [W-1:0] m_word [4];
    int           m_ptr;
    bit           m_run;
    bit           m_v;
    logic [W-1:0] m_y;
    int           m_tag;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Advance the model by one clock edge, using the inputs present at that edge.
    task automatic model_update();
        bit load;
        bit free;
        int sel;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_full[i] = 1'b0;
            m_ptr = 0; m_run = 1'b0; m_v = 1'b0; m_y = '0; m_tag = 0;
            return;
        end
        free = !m_v || r;
        load = 1'b0;
        sel  = 0;
        if (m_run && free) begin
`ifdef TDM_MUX_SKIP_IDLE_EN
            for (int k = 0; k < 4; k++) begin
                if (!load && m_full[(m_ptr + k) % 4]) begin
                    load = 1'b1;
                    sel  = (m_ptr + k) % 4;
                end
            end
            if (load) m_ptr = (sel + 1) % 4;
`else
            sel   = m_ptr;
            load  = m_full[sel];
            m_ptr = (m_ptr + 1) % 4;
`endif
        end
        if (free) begin
            if (load) begin
                m_y = m_word[sel]; m_tag = sel; m_v = 1'b1;
                if (verbose) $display("xfer ch=%0d y=%02h t=%0t", sel, m_word[sel], $time);
            end else begin
                m_v = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (load && i == sel) m_full[i] = 1'b0;
            else if (vin[i] && !m_full[i]) begin
                m_full[i] = 1'b1;
                m_word[i] = din[i];
            end
        end
        m_run = e;
    endtask

    task automatic compare_model(input string nm);
        logic [3:0] exp_rdy;
        for (int i = 0; i < 4; i++) exp_rdy[i] = !m_full[i] && !rst;
        chk({nm, " v"},   32'(v), 32'(m_v));
        chk({nm, " y"},   32'(y), 32'(m_y));
        chk({nm, " tag"}, 32'({s1, s2}), 32'(m_tag));
        chk({nm, " rdy"}, 32'({rd, rc, rb, ra}), 32'(exp_rdy));
    endtask

    task automatic step(input string nm);
        @(posedge clk);
        model_update();
        #1;
        compare_model(nm);
    endtask

    task automatic do_reset();
        rst = 1'b1; e = 1'b0; r = 1'b1; vin = 4'b0000;
        step("rst");
        step("rst");
        rst = 1'b0;
    endtask

    typedef struct {
        bit           rst;
        bit           e;
        bit           r;
        bit [3:0]     vld;
        bit           exp_v;
        logic [W-1:0] exp_y;
        bit [1:0]     exp_tag;
        bit [3:0]     exp_rdy;
    } vec_t;

    vec_t tbl [10];
    bit   found;

    initial begin
        rst = 1'b1; e = 1'b0; r = 1'b1; vin = 4'b0000;
        for (int i = 0; i < 4; i++) din[i] = '0;

        // Reset, release, load all four words in one cycle, then drain them in consecutive slots.
        tbl[0] = '{1, 0, 1, 4'b0000, 0, 8'h00, 2'd0, 4'b0000};
        tbl[1] = '{1, 0, 1, 4'b0000, 0, 8'h00, 2'd0, 4'b0000};
        tbl[2] = '{0, 0, 1, 4'b0000, 0, 8'h00, 2'd0, 4'b1111};
        tbl[3] = '{0, 0, 1, 4'b1111, 0, 8'h00, 2'd0, 4'b0000};
        tbl[4] = '{0, 1, 1, 4'b0000, 0, 8'h00, 2'd0, 4'b0000};
        tbl[5] = '{0, 1, 1, 4'b0000, 1, 8'h11, 2'd0, 4'b0001};
        tbl[6] = '{0, 1, 1, 4'b0000, 1, 8'h22, 2'd1, 4'b0011};
        tbl[7] = '{0, 1, 1, 4'b0000, 1, 8'h33, 2'd2, 4'b0111};
        tbl[8] = '{0, 1, 1, 4'b0000, 1, 8'h44, 2'd3, 4'b1111};
        tbl[9] = '{0, 1, 1, 4'b0000, 0, 8'h44, 2'd3, 4'b1111};

        din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'h33; din[3] = 8'h44;
        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst; e = tbl[i].e; r = tbl[i].r; vin = tbl[i].vld;
            step("tbl_model");
            chk($sformatf("tbl[%0d] v", i),   32'(v), 32'(tbl[i].exp_v));
            chk($sformatf("tbl[%0d] y", i),   32'(y), 32'(tbl[i].exp_y));
            chk($sformatf("tbl[%0d] tag", i), 32'({s1, s2}), 32'(tbl[i].exp_tag));
            chk($sformatf("tbl[%0d] rdy", i), 32'({rd, rc, rb, ra}), 32'(tbl[i].exp_rdy));
        end

        // Only channel c holds a word, and ptr starts at a.
        do_reset();
        din[2] = 8'hC5; vin = 4'b0100;
        step("c_only");
        vin = 4'b0000; e = 1'b1;
        step("c_only");
`ifdef TDM_MUX_SKIP_IDLE_EN
        step("c_only");
        chk("skip c v", 32'(v), 32'd1);
        chk("skip c y", 32'(y), 32'hC5);
        chk("skip c tag", 32'({s1, s2}), 32'd2);
        // ptr now points at d, so d must be served before a.
        din[0] = 8'hA1; din[3] = 8'hD3; vin = 4'b1001;
        step("c_only");
        vin = 4'b0000;
        step("c_only");
        chk("skip d first y", 32'(y), 32'hD3);
        chk("skip d first tag", 32'({s1, s2}), 32'd3);
        step("c_only");
        chk("skip a next y", 32'(y), 32'hA1);
`else
        step("c_only");
        chk("tdm a slot v", 32'(v), 32'd0);
        step("c_only");
        chk("tdm b slot v", 32'(v), 32'd0);
        step("c_only");
        chk("tdm c slot v", 32'(v), 32'd1);
        chk("tdm c slot y", 32'(y), 32'hC5);
        chk("tdm c slot tag", 32'({s1, s2}), 32'd2);
`endif

        // Back-pressure: hold for three cycles, then exactly one transfer.
        do_reset();
        din[0] = 8'h5A; vin = 4'b0001;
        step("stall");
        vin = 4'b0000; e = 1'b1; r = 1'b0;
        step("stall");
        step("stall");
        for (int k = 0; k < 3; k++) begin
            step("stall");
            chk("stall v", 32'(v), 32'd1);
            chk("stall y", 32'(y), 32'h5A);
            chk("stall tag", 32'({s1, s2}), 32'd0);
        end
        r = 1'b1;
        step("stall");
        chk("no dup v", 32'(v), 32'd0);
        step("stall");
        chk("no dup v2", 32'(v), 32'd0);

        // Scheduler disabled while d is buffered.
        do_reset();
        din[3] = 8'hDD; vin = 4'b1000;
        step("idle_d");
        vin = 4'b0000;
        step("idle_d");
        chk("idle rd", 32'(rd), 32'd0);
        chk("idle v", 32'(v), 32'd0);
        step("idle_d");
        chk("idle v2", 32'(v), 32'd0);
        e = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            step("idle_d");
            if (v) found = 1'b1;
        end
        chk("dd presented", 32'(found), 32'd1);
        chk("dd y", 32'(y), 32'hDD);
        chk("dd tag", 32'({s1, s2}), 32'd3);

        // Reset while a word is presented and two channels are still full.
        do_reset();
        din[0] = 8'h01; din[1] = 8'h02; din[2] = 8'h03; vin = 4'b0111;
        step("mid_rst");
        vin = 4'b0000; e = 1'b1; r = 1'b0;
        step("mid_rst");
        step("mid_rst");
        chk("pre-rst v", 32'(v), 32'd1);
        rst = 1'b1;
        step("mid_rst");
        chk("mid rst v", 32'(v), 32'd0);
        chk("mid rst rdy", 32'({rd, rc, rb, ra}), 32'd0);
        rst = 1'b0; r = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step("mid_rst");
            chk("no stale v", 32'(v), 32'd0);
        end

        // Random traffic against the model.
        verbose = 1'b0;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            e   = ($urandom_range(0, 9) != 0);
            r   = ($urandom_range(0, 9) < 7);
            vin = 4'($urandom);
            for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
